// File: rtl/rd_ctrl_pkg.sv
// Shared definitions for the multi-channel read FIFO request controller:
// FSM state encoding, frame-sync mode names and a constant clog2 helper.
package rd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_FSH       = 2'd3
    } state_t;

    localparam string FS_ON  = "ON";
    localparam string FS_OFF = "OFF";

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rd_fifo_multi_req_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel
// at or after i_ptr, wrapping past the last channel.
module rr_arbiter #(
    parameter int CH_NUM = 2,
    parameter int CHW    = 1
) (
    input  logic [CH_NUM-1:0] i_req,
    input  logic [CHW-1:0]    i_ptr,
    output logic [CH_NUM-1:0] o_gnt_oh,
    output logic [CHW-1:0]    o_gnt_bin,
    output logic              o_any
);

    // Search by distance from the pointer; the double loop keeps every
    // request index a constant so no variable bit-select is needed.
    always_comb begin
        logic found;
        found     = 1'b0;
        o_gnt_oh  = '0;
        o_gnt_bin = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            for (int j = 0; j < CH_NUM; j++) begin
                if (!found && i_req[j] &&
                    ((int'(i_ptr) + k == j) || (int'(i_ptr) + k == j + CH_NUM))) begin
                    found       = 1'b1;
                    o_gnt_oh[j] = 1'b1;
                    o_gnt_bin   = CHW'(j);
                end
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/rd_fifo_multi_req_ctrl.sv
// Multi-channel read-request controller: watches per-channel FIFO fill
// levels, decides when a full or frame-tail burst is due and issues the
// requests round-robin on a single read-master port.
module rd_fifo_multi_req_ctrl
    import rd_ctrl_pkg::*;
#(
    parameter int    CH_NUM     = 2,
    parameter int    CNT_W      = 9,
    parameter int    FULL_LEN   = 256,
    parameter int    THRESHOLD  = 200,
    parameter int    LSIZE      = 9,
    parameter string FRAME_SYNC = "OFF",
    // Derived from CH_NUM; not meant to be overridden.
    parameter int    CHW        = (CH_NUM > 1) ? clog2(CH_NUM) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CH_NUM-1:0]         i_enable,
    input  logic [CH_NUM*CNT_W-1:0]   i_count,
    input  logic [CH_NUM-1:0]         i_tail_status,
    input  logic [CH_NUM*LSIZE-1:0]   i_tail_len,
    input  logic [CH_NUM-1:0]         i_frame_sync,
    output logic                      o_req_valid,
    output logic                      o_req_tail,
    output logic [CHW-1:0]            o_req_ch,
    output logic [LSIZE-1:0]          o_req_len,
    input  logic                      i_resp,
    input  logic                      i_done,
    output logic                      o_busy
);

    // Compare wide enough for both the count and FULL_LEN itself.
    localparam int CMP_W = (CNT_W > clog2(FULL_LEN) + 1) ? CNT_W : clog2(FULL_LEN) + 1;
    localparam logic [CMP_W-1:0] TRIG_LIMIT = CMP_W'(FULL_LEN - THRESHOLD);
    localparam logic [LSIZE-1:0] NORM_LEN   = LSIZE'(THRESHOLD);
    localparam bit FS_EN = (FRAME_SYNC == FS_ON);

    if (THRESHOLD <= 0 || THRESHOLD > FULL_LEN || THRESHOLD >= (1 << LSIZE)) begin : g_bad_threshold
        $error("rd_fifo_multi_req_ctrl: THRESHOLD out of range");
    end
    if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch_num
        $error("rd_fifo_multi_req_ctrl: CH_NUM must be 1..8");
    end
    if (FRAME_SYNC != FS_ON && FRAME_SYNC != FS_OFF) begin : g_bad_fs_mode
        $error("rd_fifo_multi_req_ctrl: FRAME_SYNC must be ON or OFF");
    end

    state_t              r_state;
    logic                r_req_valid;
    logic                r_tail;
    logic [CHW-1:0]      r_ch;
    logic [LSIZE-1:0]    r_len;
    logic                r_busy;
    logic [CHW-1:0]      r_rr_ptr;
    logic [CH_NUM-1:0]   r_trig;

    logic [CH_NUM-1:0]   w_trig_next;
    logic [CH_NUM-1:0]   w_elig;
    logic [CH_NUM-1:0]   w_blocked;
    logic [CH_NUM-1:0]   w_gnt_oh;
    logic [CHW-1:0]      w_gnt_bin;
    logic                w_any;
    logic                w_gnt_tail;
    logic [LSIZE-1:0]    w_gnt_tail_len;
    logic [CHW-1:0]      w_ptr_next;

    genvar gi;

    // Per-channel trigger condition and eligibility; a tail with zero
    // length is never requested.
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic [CMP_W-1:0] w_cnt_ext;
        assign w_cnt_ext       = CMP_W'(i_count[gi*CNT_W +: CNT_W]);
        assign w_trig_next[gi] = i_enable[gi] && (w_cnt_ext < TRIG_LIMIT);
        assign w_elig[gi]      = r_trig[gi]
                               && !(i_tail_status[gi] && (i_tail_len[gi*LSIZE +: LSIZE] == '0))
                               && !w_blocked[gi];
    end

    // Register the fill-level trigger one cycle ahead of arbitration.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_trig <= '0;
        else       r_trig <= w_trig_next;
    end

    if (FS_EN) begin : g_fs_on
        logic [CH_NUM-1:0] r_blocked;
        logic [CH_NUM-1:0] w_blk_next;
        for (gi = 0; gi < CH_NUM; gi++) begin : g_blk
            // frame_sync wins over a block set in the same cycle.
            assign w_blk_next[gi] = i_frame_sync[gi] ? 1'b0 :
                ((r_state == ST_FSH && r_tail && r_ch == CHW'(gi)) ? 1'b1 : r_blocked[gi]);
        end
        // Hold a channel off after its tail burst until its next frame start.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) r_blocked <= '0;
            else       r_blocked <= w_blk_next;
        end
        assign w_blocked = r_blocked;
    end else begin : g_fs_off
        logic w_unused_fs;
        assign w_unused_fs = ^i_frame_sync;
        assign w_blocked   = '0;
    end

    rr_arbiter #(
        .CH_NUM (CH_NUM),
        .CHW    (CHW)
    ) u_arb (
        .i_req     (w_elig),
        .i_ptr     (r_rr_ptr),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_bin (w_gnt_bin),
        .o_any     (w_any)
    );

    assign w_gnt_tail = |(w_gnt_oh & i_tail_status);
    assign w_ptr_next = (int'(w_gnt_bin) == CH_NUM - 1) ? '0 : w_gnt_bin + 1'b1;

    // Select the granted channel's tail length.
    always_comb begin
        w_gnt_tail_len = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (w_gnt_oh[k]) w_gnt_tail_len = i_tail_len[k*LSIZE +: LSIZE];
        end
    end

    // Request FSM; grant data is latched in IDLE and held for the whole burst.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_tail      <= 1'b0;
            r_ch        <= '0;
            r_len       <= '0;
            r_busy      <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_ch        <= w_gnt_bin;
                        r_tail      <= w_gnt_tail;
                        r_len       <= w_gnt_tail ? w_gnt_tail_len : NORM_LEN;
                        r_rr_ptr    <= w_ptr_next;
                    end
                end
                ST_REQ: begin
                    if (i_resp) begin
                        r_req_valid <= 1'b0;
                        r_state     <= i_done ? ST_FSH : ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_done) r_state <= ST_FSH;
                end
                ST_FSH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_valid = r_req_valid;
    assign o_req_tail  = r_tail;
    assign o_req_ch    = r_ch;
    assign o_req_len   = r_len;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_rd_fifo_multi_req_ctrl.sv
// Bench for rd_fifo_multi_req_ctrl: a 4-channel instance without frame
// sync (table of vectors plus timing sequences) and a 2-channel instance
// with frame sync gating. Expected requests go through a scoreboard queue.
module tb_rd_fifo_multi_req_ctrl;

    logic clk;
    logic rst;

    // 4-channel, FRAME_SYNC off
    logic [3:0]  a_en, a_ts, a_fs;
    logic [35:0] a_cnt, a_tl;
    logic        a_resp, a_done;
    logic        a_req_valid, a_req_tail, a_busy;
    logic [1:0]  a_req_ch;
    logic [8:0]  a_req_len;

    // 2-channel, FRAME_SYNC on
    logic [1:0]  b_en, b_ts, b_fs;
    logic [17:0] b_cnt, b_tl;
    logic        b_resp, b_done;
    logic        b_req_valid, b_req_tail, b_busy;
    logic [0:0]  b_req_ch;
    logic [8:0]  b_req_len;

    int total = 0;
    int bad   = 0;
    bit got;
    bit seen;

    typedef struct {
        int ch;
        int len;
        bit tail;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [3:0]  en;
        logic [35:0] cnt;
        logic [3:0]  ts;
        logic [35:0] tl;
        bit          ev;
        int          ech;
        int          elen;
        bit          etail;
    } vec_t;
    vec_t tbl[13];

    rd_fifo_multi_req_ctrl #(
        .CH_NUM(4), .CNT_W(9), .FULL_LEN(256), .THRESHOLD(200), .LSIZE(9), .FRAME_SYNC("OFF")
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_enable(a_en), .i_count(a_cnt),
        .i_tail_status(a_ts), .i_tail_len(a_tl), .i_frame_sync(a_fs),
        .o_req_valid(a_req_valid), .o_req_tail(a_req_tail), .o_req_ch(a_req_ch),
        .o_req_len(a_req_len), .i_resp(a_resp), .i_done(a_done), .o_busy(a_busy)
    );

    rd_fifo_multi_req_ctrl #(
        .CH_NUM(2), .CNT_W(9), .FULL_LEN(256), .THRESHOLD(200), .LSIZE(9), .FRAME_SYNC("ON")
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_enable(b_en), .i_count(b_cnt),
        .i_tail_status(b_ts), .i_tail_len(b_tl), .i_frame_sync(b_fs),
        .o_req_valid(b_req_valid), .o_req_tail(b_req_tail), .o_req_ch(b_req_ch),
        .o_req_len(b_req_len), .i_resp(b_resp), .i_done(b_done), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic sb_push(input int ch, input int len, input bit tail);
        exp_t e;
        e.ch = ch; e.len = len; e.tail = tail;
        sb_q.push_back(e);
    endtask

    task automatic sb_drop();
        if (sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    task automatic sb_cmp(input string tag, input int ch, input int len, input int tail);
        exp_t e;
        $display("txn %s ch=%0d len=%0d tail=%0d", tag, ch, len, tail);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb: got request on ch %0d, want none", tag, ch);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ch"}, ch, e.ch);
            chk({tag, "_len"}, len, e.len);
            chk({tag, "_tail"}, tail, int'(e.tail));
        end
    endtask

    task automatic wait_req_a(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(posedge clk); #1;
            if (a_req_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_req_b(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(posedge clk); #1;
            if (b_req_valid) ok = 1'b1;
        end
    endtask

    // Called in REQ; returns once the DUT is back in IDLE.
    task automatic hs_a(input bit coincide, input bit drop_en);
        a_resp = 1'b1;
        a_done = coincide;
        @(posedge clk); #1;
        a_resp = 1'b0;
        a_done = 1'b0;
        if (drop_en) a_en = '0;
        if (!coincide) begin
            a_done = 1'b1;
            @(posedge clk); #1;
            a_done = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic [3:0] en, input int cnt_all, input int cnt_ch,
                                input int cnt_val, input logic [3:0] ts, input int tl_val,
                                input bit ev, input int ech, input int elen, input bit etail);
        vec_t v;
        v.en = en;
        v.ts = ts;
        for (int k = 0; k < 4; k++) begin
            v.cnt[k*9 +: 9] = (k == cnt_ch) ? 9'(cnt_val) : 9'(cnt_all);
            v.tl[k*9 +: 9]  = 9'(tl_val);
        end
        v.ev = ev; v.ech = ech; v.elen = elen; v.etail = etail;
        return v;
    endfunction

    initial begin
        // Round-robin pointer is 1 when the table starts (one ch0 grant before it).
        tbl[0]  = mk(4'b0001,   0, 0,  50, 4'b0000,   0, 1, 0, 200, 0);
        tbl[1]  = mk(4'b0001,   0, 0,  56, 4'b0000,   0, 0, 0,   0, 0);
        tbl[2]  = mk(4'b0001,   0, 0,  55, 4'b0000,   0, 1, 0, 200, 0);
        tbl[3]  = mk(4'b1111,   0, 0,   0, 4'b0000,   0, 1, 1, 200, 0);
        tbl[4]  = mk(4'b1001,   0, 0,   0, 4'b0000,   0, 1, 3, 200, 0);
        tbl[5]  = mk(4'b0010,   0, 0,   0, 4'b0010,  37, 1, 1,  37, 1);
        tbl[6]  = mk(4'b0100,   0, 0,   0, 4'b0100,   0, 0, 0,   0, 0);
        tbl[7]  = mk(4'b0110,   0, 0,   0, 4'b0100,   0, 1, 1, 200, 0);
        tbl[8]  = mk(4'b1000, 300, 0, 300, 4'b0000,   0, 0, 0,   0, 0);
        tbl[9]  = mk(4'b1000,   0, 0,   0, 4'b1000, 511, 1, 3, 511, 1);
        tbl[10] = mk(4'b0000,   0, 0,   0, 4'b0000,   0, 0, 0,   0, 0);
        tbl[11] = mk(4'b0001,   0, 0,   0, 4'b0001,   1, 1, 0,   1, 1);
        tbl[12] = mk(4'b0001,   0, 0, 511, 4'b0000,   0, 0, 0,   0, 0);

        rst = 1'b1;
        a_en = '0; a_cnt = '0; a_ts = '0; a_tl = '0; a_fs = '0; a_resp = 1'b0; a_done = 1'b0;
        b_en = '0; b_cnt = '0; b_ts = '0; b_tl = '0; b_fs = '0; b_resp = 1'b0; b_done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", a_req_valid, 0);
        chk("rst_tail", a_req_tail, 0);
        chk("rst_ch", a_req_ch, 0);
        chk("rst_len", a_req_len, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_b_busy", b_busy, 0);
        rst = 1'b0;

        // Latency, stable latched request, resp then done later, enable drop
        a_en = 4'b0001;
        a_cnt = 36'd50;
        sb_push(0, 200, 0);
        @(posedge clk); #1;
        chk("lat_edge1_valid", a_req_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge2_valid", a_req_valid, 1);
        chk("lat_edge2_busy", a_busy, 1);
        sb_cmp("lat", a_req_ch, a_req_len, a_req_tail);
        a_cnt = 36'd300;
        a_ts = 4'b0001;
        a_tl = 36'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_valid", a_req_valid, 1);
        chk("hold_len", a_req_len, 200);
        chk("hold_tail", a_req_tail, 0);
        a_resp = 1'b1;
        @(posedge clk); #1;
        a_resp = 1'b0;
        a_en = '0;
        chk("wd_valid", a_req_valid, 0);
        chk("wd_busy", a_busy, 1);
        @(posedge clk); #1;
        chk("wd_hold_busy", a_busy, 1);
        a_done = 1'b1;
        @(posedge clk); #1;
        a_done = 1'b0;
        chk("fsh_busy", a_busy, 1);
        @(posedge clk); #1;
        chk("idle_busy", a_busy, 0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (a_req_valid) seen = 1'b1;
        end
        chk("disabled_no_req", seen, 0);
        a_ts = '0;

        // Table of vectors
        for (int i = 0; i < 13; i++) begin
            a_en  = tbl[i].en;
            a_cnt = tbl[i].cnt;
            a_ts  = tbl[i].ts;
            a_tl  = tbl[i].tl;
            if (tbl[i].ev) sb_push(tbl[i].ech, tbl[i].elen, tbl[i].etail);
            wait_req_a(8, got);
            chk($sformatf("v%0d_req_seen", i), got, tbl[i].ev);
            if (got) begin
                sb_cmp($sformatf("v%0d", i), a_req_ch, a_req_len, a_req_tail);
                hs_a(1'b1, 1'b1);
            end else if (tbl[i].ev) begin
                sb_drop();
            end
            a_en = '0;
            repeat (3) @(posedge clk);
            #1;
        end

        // resp and done together: FSH, IDLE, then the next request
        a_en = 4'b0001;
        a_cnt = '0;
        a_ts = '0;
        sb_push(0, 200, 0);
        wait_req_a(8, got);
        chk("co_req_seen", got, 1);
        if (got) sb_cmp("co1", a_req_ch, a_req_len, a_req_tail);
        else sb_drop();
        a_resp = 1'b1;
        a_done = 1'b1;
        @(posedge clk); #1;
        a_resp = 1'b0;
        a_done = 1'b0;
        chk("co_fsh_valid", a_req_valid, 0);
        chk("co_fsh_busy", a_busy, 1);
        @(posedge clk); #1;
        chk("co_idle_busy", a_busy, 0);
        chk("co_idle_valid", a_req_valid, 0);
        sb_push(0, 200, 0);
        @(posedge clk); #1;
        chk("co_respace_valid", a_req_valid, 1);
        if (a_req_valid) sb_cmp("co2", a_req_ch, a_req_len, a_req_tail);
        else sb_drop();
        hs_a(1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Frame-sync gating on the 2-channel instance
        b_en = 2'b10;
        b_ts = 2'b10;
        b_tl = {9'd37, 9'd0};
        sb_push(1, 37, 1);
        wait_req_b(8, got);
        chk("b1_req_seen", got, 1);
        if (got) sb_cmp("b1", int'(b_req_ch), b_req_len, b_req_tail);
        else sb_drop();
        b_resp = 1'b1;
        b_done = 1'b1;
        @(posedge clk); #1;
        b_resp = 1'b0;
        b_done = 1'b0;
        b_ts = 2'b00;
        chk("b1_fsh_busy", b_busy, 1);
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (b_req_valid) seen = 1'b1;
        end
        chk("b1_blocked", seen, 0);
        b_fs = 2'b10;
        @(posedge clk); #1;
        b_fs = 2'b00;
        sb_push(1, 200, 0);
        wait_req_b(3, got);
        chk("b1_unblock_seen", got, 1);
        if (got) sb_cmp("b1u", int'(b_req_ch), b_req_len, b_req_tail);
        else sb_drop();

        // frame_sync during the tail burst's FSH cycle keeps the channel eligible
        b_resp = 1'b1;
        b_done = 1'b1;
        @(posedge clk); #1;
        b_resp = 1'b0;
        b_done = 1'b0;
        b_ts = 2'b10;
        @(posedge clk); #1;
        sb_push(1, 37, 1);
        wait_req_b(2, got);
        chk("b2_tail_seen", got, 1);
        if (got) sb_cmp("b2t", int'(b_req_ch), b_req_len, b_req_tail);
        else sb_drop();
        b_resp = 1'b1;
        b_done = 1'b1;
        @(posedge clk); #1;
        b_resp = 1'b0;
        b_done = 1'b0;
        b_ts = 2'b00;
        b_fs = 2'b10;
        @(posedge clk); #1;
        b_fs = 2'b00;
        sb_push(1, 200, 0);
        @(posedge clk); #1;
        chk("b2_keep_elig", b_req_valid, 1);
        if (b_req_valid) sb_cmp("b2n", int'(b_req_ch), b_req_len, b_req_tail);
        else sb_drop();
        b_resp = 1'b1;
        b_done = 1'b1;
        @(posedge clk); #1;
        b_resp = 1'b0;
        b_done = 1'b0;
        b_en = '0;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while waiting for done
        a_en = 4'b0010;
        a_cnt = '0;
        sb_push(1, 200, 0);
        wait_req_a(8, got);
        chk("ar_req_seen", got, 1);
        if (got) sb_cmp("ar", a_req_ch, a_req_len, a_req_tail);
        else sb_drop();
        a_resp = 1'b1;
        @(posedge clk); #1;
        a_resp = 1'b0;
        chk("ar_wd_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("ar_busy", a_busy, 0);
        chk("ar_valid", a_req_valid, 0);
        chk("ar_ch", a_req_ch, 0);
        chk("ar_len", a_req_len, 0);
        chk("ar_tail", a_req_tail, 0);
        a_en = 4'b1111;
        @(posedge clk); #1;
        rst = 1'b0;

        // Round-robin order after reset with every channel always requesting
        for (int k = 0; k < 5; k++) sb_push(k % 4, 200, 0);
        for (int t = 0; t < 5; t++) begin
            wait_req_a(8, got);
            chk($sformatf("rr%0d_seen", t), got, 1);
            if (got) begin
                sb_cmp($sformatf("rr%0d", t), a_req_ch, a_req_len, a_req_tail);
                hs_a(1'b0, t == 4);
            end else begin
                sb_drop();
            end
        end
        a_en = '0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
